// File: rtl/set_bit_scanner.sv
// Enumerates the set bits of a word, lowest first, one index per output beat.
// Latency: first beat one cycle after acceptance; one beat per cycle when dout_ready is held high.
// Backpressure: beats hold while dout_ready is low; a new word is accepted only when idle or on the last-beat handshake.
module set_bit_scanner #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [$clog2(DATA_WIDTH):0]   dout,
  output logic [$clog2(DATA_WIDTH)-1:0] dout_seq,
  output logic                          dout_last,
  output logic                          dout_valid,
  input  logic                          dout_ready
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shadow;
  logic [SW-1:0]         seq;

  logic [DATA_WIDTH-1:0] shadow_clr;
  logic [CW-1:0]         tz;
  logic                  at_most_one;
  logic                  beat_hs;
  logic                  accept;

  // Lowest set bit cleared, and whether that leaves nothing behind
  always_comb begin
    shadow_clr  = shadow & (shadow - DATA_WIDTH'(1));
    at_most_one = (shadow_clr == '0);
  end

  // Trailing-zero count; scanning from the top lets the lowest set bit win, all-zero gives DATA_WIDTH
  always_comb begin
    tz = CW'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (shadow[i]) tz = CW'(i);
    end
  end

  // Output beat and input ready, all forced to zero outside SCAN except ready
  always_comb begin
    dout_valid = (state == SCAN);
    dout       = dout_valid ? tz : '0;
    dout_seq   = dout_valid ? seq : '0;
    dout_last  = dout_valid & at_most_one;
    beat_hs    = dout_valid & dout_ready;
    din_ready  = (state == IDLE) | (dout_last & dout_ready);
    accept     = din_valid & din_ready;
  end

  // Word capture, bit-by-bit consumption and end-of-word return to IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      shadow <= '0;
      seq    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shadow <= din;
            seq    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (accept) begin
            // Last beat handed off on the same edge a new word arrives
            shadow <= din;
            seq    <= '0;
            state  <= SCAN;
          end else if (beat_hs) begin
            if (dout_last) begin
              shadow <= '0;
              seq    <= '0;
              state  <= IDLE;
            end else begin
              shadow <= shadow_clr;
              seq    <= seq + SW'(1);
            end
          end
        end
        default: begin
          shadow <= '0;
          seq    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Bench for set_bit_scanner at DATA_WIDTH = 8: directed scenarios then random traffic.
// Reference keeps the expected beats of the current word as a queue built from the word's set bits.
// Checks every cycle against the queue head; reset clears the queue.
module tb_set_bit_scanner;

  typedef struct {
    int idx;
    int seq;
    bit last;
  } beat_t;

  logic       clk;
  logic       resetn;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] dout;
  logic [2:0] dout_seq;
  logic       dout_last;
  logic       dout_valid;
  logic       dout_ready;

  int checks;
  int errors;
  beat_t exp_q[$];

  set_bit_scanner #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_seq   (dout_seq),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected beat list for a word: one entry per set bit, or a single DATA_WIDTH beat for zero
  task automatic push_word(input logic [7:0] w);
    int n;
    int k;
    beat_t b;
    n = $countones(w);
    if (n == 0) begin
      b.idx = 8; b.seq = 0; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (w[i]) begin
          b.idx = i; b.seq = k; b.last = (k == n - 1);
          exp_q.push_back(b);
          k++;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, compare outputs, advance the reference across the next edge
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit    e_valid;
    bit    e_ready;
    beat_t h;
    din_valid  = v;
    din        = d;
    dout_ready = r;
    #1;
    e_valid = (exp_q.size() != 0);
    if (e_valid) h = exp_q[0];
    else begin h.idx = 0; h.seq = 0; h.last = 1'b0; end
    e_ready = !e_valid || (h.last && r);
    check_eq("dout_valid", int'(dout_valid), int'(e_valid));
    check_eq("dout",       int'(dout),       h.idx);
    check_eq("dout_seq",   int'(dout_seq),   h.seq);
    check_eq("dout_last",  int'(dout_last),  int'(h.last));
    check_eq("din_ready",  int'(din_ready),  int'(e_ready));
    if (e_valid && r) void'(exp_q.pop_front());
    if (v && e_ready) push_word(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(dout_valid), 0);
    check_eq({tag, "_dout"},  int'(dout),       0);
    check_eq({tag, "_seq"},   int'(dout_seq),   0);
    check_eq({tag, "_last"},  int'(dout_last),  0);
    check_eq({tag, "_ready"}, int'(din_ready),  1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // First word taken on the first edge after release; 0x2C -> 2,3,5
    step(1'b1, 8'h2C, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // All-zero word -> single beat of 8
    step(1'b1, 8'h00, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // 0x81 with three stalled cycles, then 0 and 7
    step(1'b1, 8'h81, 1'b0);
    repeat (3) step(1'b1, 8'h55, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // 0x01 then 0x80 presented during its last-beat handshake
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b1);

    // 0xFF full run: 0..7 with dout_seq reaching 7
    step(1'b1, 8'hFF, 1'b1);
    repeat (9) step(1'b0, 8'h00, 1'b1);

    // 0xFF interrupted by reset after the third beat
    step(1'b1, 8'hFF, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    check_eq("pre_reset_valid", int'(dout_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Random traffic with biased corner words
    for (int n = 0; n < 400; n++) begin
      logic [7:0] w;
      int sel;
      sel = $urandom_range(0, 9);
      w = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      step(($urandom_range(0, 2) != 0), w, ($urandom_range(0, 3) != 0));
    end
    repeat (10) step(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
